adder32_rr_arbiter: RTL and testbench

Shares one registered 32-bit adder core (adder32: 1-cycle latency, sync active-low reset) among NREQ requesters. Each requester has a valid/ready request channel (operands, carry-in) and a valid/ready response channel. Grants are round-robin, with at most one issue per cycle. The block tracks the in-flight operation and routes each sum back to its owner, including under response backpressure.

---
 rtl/adder32_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_adder32_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder32_rr_arbiter.sv
// Round-robin front end that shares one registered 32-bit adder among NREQ requesters,
// tracking the single in-flight operation and returning its sum to the owner.

module adder32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum_out,
  output logic        c_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_out <= '0;
      c_out   <= 1'b0;
    end else begin
      {c_out, sum_out} <= {1'b0, a} + {1'b0, b} + {32'b0, c_in};
    end
  end

endmodule

module adder32_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  logic [IDW-1:0] rr_ptr;
  logic           issue_vld_q;
  logic [IDW-1:0] issue_id_q;
  logic [31:0]    last_a;
  logic [31:0]    last_b;
  logic           last_c;

  logic [31:0]    a_arr [NREQ];
  logic [31:0]    b_arr [NREQ];
  logic           stall;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   scan_idx;
  logic           fire;
  logic [31:0]    add_a;
  logic [31:0]    add_b;
  logic           add_c;
  logic [IDW-1:0] ptr_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[32*gi +: 32];
      assign b_arr[gi]     = req_b[32*gi +: 32];
      assign rsp_valid[gi] = issue_vld_q & (issue_id_q == IDW'(gi));
    end
  endgenerate

  // The owner's rsp_ready feeds req_ready combinationally: a new issue may
  // coincide with acceptance of the previous response.
  assign stall = issue_vld_q & ~rsp_ready[issue_id_q];

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[IDW-1:0];
      end
    end
  end

  assign fire      = grant_found & rst_n & ~stall;
  assign req_ready = fire ? (NREQ'(1) << grant_id) : '0;
  assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // Replaying the last operands keeps sum_out steady while stalled or idle.
  assign add_a = fire ? a_arr[grant_id]   : last_a;
  assign add_b = fire ? b_arr[grant_id]   : last_b;
  assign add_c = fire ? req_cin[grant_id] : last_c;

  adder32 u_adder (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (add_a),
    .b       (add_b),
    .c_in    (add_c),
    .sum_out (rsp_sum),
    .c_out   (rsp_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      issue_vld_q <= 1'b0;
      issue_id_q  <= '0;
      last_a      <= '0;
      last_b      <= '0;
      last_c      <= 1'b0;
    end else if (fire) begin
      last_a      <= add_a;
      last_b      <= add_b;
      last_c      <= add_c;
      issue_vld_q <= 1'b1;
      issue_id_q  <= grant_id;
      rr_ptr      <= ptr_next;
    end else if (!stall) begin
      issue_vld_q <= 1'b0;
    end
  end

  assign busy = issue_vld_q;

endmodule

// File: tb/tb_adder32_rr_arbiter.sv
// Bench for adder32_rr_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level reference model.

module tb_adder32_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a = '0;
  logic [32*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_cin = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;
  logic                busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: next-priority requester, outstanding result and its owner.
  int              m_ptr = 0;
  int              m_id = 0;
  bit              m_vld = 1'b0;
  logic [32:0]     m_sum = '0;
  logic [NREQ-1:0] exp_ready = '0;
  logic [NREQ-1:0] obs_ready = '0;

  adder32_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_sum(int i);
    return 33'(req_a[i*32 +: 32]) + 33'(req_b[i*32 +: 32]) + 33'(req_cin[i]);
  endfunction

  function automatic logic [NREQ-1:0] model_rsp_valid();
    return m_vld ? (NREQ'(1) << m_id) : '0;
  endfunction

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = c;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
  endtask

  // One clock: sample req_ready before the edge, advance the model at the edge,
  // return 1 time unit after the edge so registered outputs can be inspected.
  task automatic cycle();
    int  g;
    bit  found;
    bit  stall_m;
    bit  acc;
    int  acc_id;
    #1;
    obs_ready = req_ready;
    stall_m   = m_vld && !rsp_ready[m_id];
    found     = 1'b0;
    g         = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(m_ptr + k) % NREQ]) begin
        found = 1'b1;
        g     = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = '0;
    if (found && rst_n && !stall_m) exp_ready[g] = 1'b1;
    acc    = rst_n && m_vld && rsp_ready[m_id];
    acc_id = m_id;
    if (acc) $display("resp  req%0d sum=%h cout=%0d", acc_id, m_sum[31:0], m_sum[32]);
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_vld = 1'b0; m_id = 0; m_sum = '0;
    end else if (exp_ready != '0) begin
      m_sum = ref_sum(g);
      m_vld = 1'b1;
      m_id  = g;
      m_ptr = (g + 1) % NREQ;
      $display("issue req%0d a=%h b=%h cin=%0d", g, req_a[g*32 +: 32], req_b[g*32 +: 32], req_cin[g]);
    end else if (!stall_m) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; rsp_ready = '1;
    randomize_ops();
    cycle();
    n_cmp++; if (obs_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", obs_ready); end
    cycle();
    n_cmp++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if ({rsp_cout, rsp_sum} !== 33'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", {rsp_cout, rsp_sum}); end
    rst_n = 1'b1; req_valid = '0;
    cycle();
    n_cmp++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL post_reset_rsp_valid: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_single_op();
    set_op(1, 32'h5, 32'h3, 1'b1);
    req_valid = 4'b0010; rsp_ready = '1;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL single_req_ready: got %b expected 0010", obs_ready); end
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0010", rsp_valid); end
    n_cmp++; if (rsp_sum !== 32'h9 || rsp_cout !== 1'b0) begin n_fail++; $display("FAIL single_sum: got %b_%h expected 0_00000009", rsp_cout, rsp_sum); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    req_valid = '0;
    cycle();
    n_cmp++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_accept: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_carry_wrap();
    set_op(0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req_valid = 4'b0001;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_req_ready: got %b expected 0001", obs_ready); end
    n_cmp++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin n_fail++; $display("FAIL wrap_sum1: got %b_%h expected 1_00000000", rsp_cout, rsp_sum); end
    set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    cycle();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL wrap_rsp_valid2: got %b expected 0001", rsp_valid); end
    n_cmp++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin n_fail++; $display("FAIL wrap_sum2: got %b_%h expected 1_00000000", rsp_cout, rsp_sum); end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    logic [32:0] e;
    rst_n = 1'b0; req_valid = '0;
    cycle();
    rst_n = 1'b1; req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      randomize_ops();
      e = ref_sum(k % NREQ);
      cycle();
      n_cmp++; if (obs_ready !== (NREQ'(1) << (k % NREQ))) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected req%0d", k, obs_ready, k % NREQ); end
      n_cmp++; if (rsp_valid !== (NREQ'(1) << (k % NREQ)) || {rsp_cout, rsp_sum} !== e) begin
        n_fail++; $display("FAIL rr_rsp%0d: got %b %h expected req%0d %h", k, rsp_valid, {rsp_cout, rsp_sum}, k % NREQ, e);
      end
    end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_back_pressure();
    logic [32:0] e;
    set_op(2, 32'h10, 32'h20, 1'b0);
    req_valid = 4'b0100; rsp_ready = 4'b1011;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_issue: got %b expected 0100", obs_ready); end
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      set_op(0, $urandom(), $urandom(), 1'b1);
      set_op(3, $urandom(), $urandom(), 1'b0);
      cycle();
      n_cmp++; if (obs_ready !== '0) begin n_fail++; $display("FAIL bp_stall_ready%0d: got %b expected 0000", k, obs_ready); end
      n_cmp++; if (rsp_valid !== 4'b0100 || rsp_sum !== 32'h30 || rsp_cout !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got %b %h expected 0100 00000030", k, rsp_valid, rsp_sum);
      end
    end
    rsp_ready = '1;
    e = ref_sum(3);
    cycle();
    n_cmp++; if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_grant: got %b expected 1000", obs_ready); end
    n_cmp++; if (rsp_valid !== 4'b1000 || {rsp_cout, rsp_sum} !== e) begin n_fail++; $display("FAIL bp_release_rsp: got %b %h expected 1000 %h", rsp_valid, {rsp_cout, rsp_sum}, e); end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_reset_mid_op();
    set_op(3, $urandom(), $urandom(), 1'b1);
    req_valid = 4'b1000;
    cycle();
    n_cmp++; if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_fire: got %b expected 1000", obs_ready); end
    req_valid = '0; rst_n = 1'b0;
    cycle();
    n_cmp++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %b busy=%b expected 0000 busy=0", rsp_valid, busy); end
    n_cmp++; if ({rsp_cout, rsp_sum} !== 33'h0) begin n_fail++; $display("FAIL mid_sum: got %h expected 0", {rsp_cout, rsp_sum}); end
    rst_n = 1'b1; req_valid = 4'b1001;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 0001", obs_ready); end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_idle_retention();
    req_valid = 4'b0010;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL idle_grant1: got %b expected 0010", obs_ready); end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_quiet%0d: got %b busy=%b expected 0000 busy=0", k, rsp_valid, busy); end
    end
    req_valid = 4'b0110;
    cycle();
    n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL idle_ptr_kept: got %b expected 0100", obs_ready); end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      randomize_ops();
      cycle();
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", n, obs_ready, exp_ready); end
      n_cmp++; if (rsp_valid !== model_rsp_valid() || busy !== m_vld) begin
        n_fail++; $display("FAIL rand_valid@%0d: got %b busy=%b expected %b busy=%b", n, rsp_valid, busy, model_rsp_valid(), m_vld);
      end
      n_cmp++; if ({rsp_cout, rsp_sum} !== m_sum) begin n_fail++; $display("FAIL rand_sum@%0d: got %h expected %h", n, {rsp_cout, rsp_sum}, m_sum); end
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = '1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_carry_wrap();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    test_idle_retention();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
